// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I control unit: opcode classes,
// FSM state encoding, datapath mux/ALU encodings and the retirement rule.
package ctrl_pkg;

    // RV32I major opcodes (instruction bits [6:0])
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Encodings 6 and 7 are unused and treated as a corrupted state
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // ALU operand A select
    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_RS1    = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    // ALU operation
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_PASSB = 2'b11;

    // Register file write-back source
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    // An instruction retires whenever the FSM re-enters FETCH from elsewhere
    function automatic logic retires(input state_t cur, input state_t nxt);
        return (nxt == S_FETCH) && (cur != S_FETCH);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles of one access and flags when the wait limit is
// reached with the memory still not ready. LIMIT of 0 disables the timeout.
module mem_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic done,
    input  logic clear,
    output logic expired
);

    localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

    logic [CW-1:0] count;

    // Wait-cycle counter: restarts on reset, handshake or state change, holds at the limit
    always_ff @(posedge clk) begin
        if (!rst_n || clear || done) begin
            count <= '0;
        end else if (enable && (count != CW'(LIMIT))) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (LIMIT != 0) && enable && (count == CW'(LIMIT));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath selects, handles the memory
// ready handshake with a wait timeout, and counts retired instructions.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter bit SYSTEM_HALT = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             branch,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             timeout,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    state_t           state_q, state_d;
    logic [6:0]       opc_q;
    logic             illegal_q, timeout_q;
    logic [CNT_W-1:0] instret_q;
    logic             set_illegal, set_timeout;
    logic             expired;

    // Ungated control values; forced to zero during reset at the ports
    logic       c_mem_req, c_mem_we, c_ir_write, c_pc_write, c_pc_src;
    logic       c_reg_write, c_branch;
    logic [1:0] c_alu_src_a, c_alu_src_b, c_alu_op, c_wb_sel;

    mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (c_mem_req && !mem_ready),
        .done    (c_mem_req && mem_ready),
        .clear   (state_d != state_q),
        .expired (expired)
    );

    // Next-state and per-state control decode
    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        c_mem_req   = 1'b0;
        c_mem_we    = 1'b0;
        c_ir_write  = 1'b0;
        c_pc_write  = 1'b0;
        c_pc_src    = 1'b0;
        c_reg_write = 1'b0;
        c_branch    = 1'b0;
        c_alu_src_a = SRC_A_PC;
        c_alu_src_b = SRC_B_RS2;
        c_alu_op    = ALU_ADD;
        c_wb_sel    = WB_ALU;

        case (state_q)
            S_FETCH: begin
                c_mem_req   = 1'b1;
                c_alu_src_a = SRC_A_PC;
                c_alu_src_b = SRC_B_FOUR;
                c_alu_op    = ALU_ADD;
                if (mem_ready) begin
                    c_ir_write = 1'b1;
                    c_pc_write = 1'b1;
                    c_pc_src   = 1'b0;
                    state_d    = S_DECODE;
                end else if (expired) begin
                    state_d     = S_HALT;
                    set_timeout = 1'b1;
                end
            end
            S_DECODE: begin
                // Precompute the branch/jump target into ALUOut
                c_alu_src_a = SRC_A_OLD_PC;
                c_alu_src_b = SRC_B_IMM;
                c_alu_op    = ALU_ADD;
                case (opcode)
                    OPC_R, OPC_I_ALU, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                    OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC:
                        state_d = S_EXEC;
                    OPC_SYSTEM:
                        state_d = SYSTEM_HALT ? S_HALT : S_FETCH;
                    default: begin
                        state_d     = S_HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                case (opc_q)
                    OPC_R: begin
                        c_alu_src_a = SRC_A_RS1;
                        c_alu_src_b = SRC_B_RS2;
                        c_alu_op    = ALU_FUNCT;
                        state_d     = S_WB;
                    end
                    OPC_I_ALU: begin
                        c_alu_src_a = SRC_A_RS1;
                        c_alu_src_b = SRC_B_IMM;
                        c_alu_op    = ALU_FUNCT;
                        state_d     = S_WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        c_alu_src_a = SRC_A_RS1;
                        c_alu_src_b = SRC_B_IMM;
                        c_alu_op    = ALU_ADD;
                        state_d     = S_MEM;
                    end
                    OPC_BRANCH: begin
                        c_alu_src_a = SRC_A_RS1;
                        c_alu_src_b = SRC_B_RS2;
                        c_alu_op    = ALU_SUB;
                        c_branch    = 1'b1;
                        c_pc_write  = branch_taken;
                        c_pc_src    = 1'b1;
                        state_d     = S_FETCH;
                    end
                    OPC_JAL: begin
                        c_pc_write  = 1'b1;
                        c_pc_src    = 1'b1;
                        c_reg_write = 1'b1;
                        c_wb_sel    = WB_PC;
                        state_d     = S_FETCH;
                    end
                    OPC_JALR: begin
                        c_alu_src_a = SRC_A_RS1;
                        c_alu_src_b = SRC_B_IMM;
                        c_alu_op    = ALU_ADD;
                        c_pc_write  = 1'b1;
                        c_pc_src    = 1'b0;
                        c_reg_write = 1'b1;
                        c_wb_sel    = WB_PC;
                        state_d     = S_FETCH;
                    end
                    OPC_LUI: begin
                        c_reg_write = 1'b1;
                        c_wb_sel    = WB_IMM;
                        c_alu_op    = ALU_PASSB;
                        state_d     = S_FETCH;
                    end
                    OPC_AUIPC: begin
                        c_alu_src_a = SRC_A_OLD_PC;
                        c_alu_src_b = SRC_B_IMM;
                        c_alu_op    = ALU_ADD;
                        state_d     = S_WB;
                    end
                    default: begin
                        // Only legal opcodes reach EXEC; anything else means corruption
                        state_d     = S_HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                c_mem_req = 1'b1;
                c_mem_we  = (opc_q == OPC_STORE);
                if (mem_ready) begin
                    state_d = (opc_q == OPC_LOAD) ? S_WB : S_FETCH;
                end else if (expired) begin
                    state_d     = S_HALT;
                    set_timeout = 1'b1;
                end
            end
            S_WB: begin
                c_reg_write = 1'b1;
                c_wb_sel    = (opc_q == OPC_LOAD) ? WB_MEM : WB_ALU;
                state_d     = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d     = S_HALT;
                set_illegal = 1'b1;
            end
        endcase
    end

    // State register, opcode latch, sticky flags and retirement counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            opc_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opc_q <= opcode;
            end
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end
            if (retires(state_q, state_d)) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    // Port drive: everything reads as zero while reset is held
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        alu_src_a = 2'b00;
        alu_src_b = 2'b00;
        alu_op    = 2'b00;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        branch    = 1'b0;
        state     = 3'd0;
        illegal   = 1'b0;
        timeout   = 1'b0;
        halted    = 1'b0;
        instret   = '0;
        if (rst_n) begin
            mem_req   = c_mem_req;
            mem_we    = c_mem_we;
            ir_write  = c_ir_write;
            pc_write  = c_pc_write;
            pc_src    = c_pc_src;
            alu_src_a = c_alu_src_a;
            alu_src_b = c_alu_src_b;
            alu_op    = c_alu_op;
            reg_write = c_reg_write;
            wb_sel    = c_wb_sel;
            branch    = c_branch;
            state     = state_q;
            illegal   = illegal_q;
            timeout   = timeout_q;
            halted    = (state_q == S_HALT);
            instret   = instret_q;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MEM_TIMEOUT=3, SYSTEM_HALT=0).
// Each step applies inputs just after a rising edge and checks outputs
// a moment later, well before the next edge.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        branch_taken;
    logic        mem_req, mem_we, ir_write, pc_write, pc_src;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, wb_sel;
    logic        reg_write, branch;
    logic [2:0]  state;
    logic        illegal, timeout, halted;
    logic [31:0] instret;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] LD_OP  = 7'b0000011;
    localparam logic [6:0] ST_OP  = 7'b0100011;
    localparam logic [6:0] BR_OP  = 7'b1100011;
    localparam logic [6:0] JAL_OP = 7'b1101111;
    localparam logic [6:0] SYS_OP = 7'b1110011;
    localparam logic [6:0] BAD_OP = 7'b1111111;

    multicycle_control #(
        .MEM_TIMEOUT (3),
        .SYSTEM_HALT (1'b0),
        .CNT_W       (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .branch       (branch),
        .state        (state),
        .illegal      (illegal),
        .timeout      (timeout),
        .halted       (halted),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: wait for the edge, apply inputs, let combinational outputs settle
    task automatic step(input logic rst, input logic rdy, input logic bt, input logic [6:0] op);
        @(posedge clk);
        #1;
        rst_n        = rst;
        mem_ready    = rdy;
        branch_taken = bt;
        opcode       = op;
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        mem_ready    = 1'b1;
        branch_taken = 1'b0;
        opcode       = 7'd0;

        // Reset held: outputs forced low even with mem_ready high
        step(1'b0, 1'b1, 1'b0, R_OP);
        chk("rst_state",   32'(state), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_ir_wr",   32'(ir_write), 0);
        chk("rst_instret", instret, 0);

        // R-type: FETCH, DECODE, EXEC, WB, FETCH
        step(1'b1, 1'b1, 1'b0, R_OP);
        chk("r_f_state",  32'(state), 0);
        chk("r_f_req",    32'(mem_req), 1);
        chk("r_f_irw",    32'(ir_write), 1);
        chk("r_f_pcw",    32'(pc_write), 1);
        chk("r_f_srcb",   32'(alu_src_b), 1);
        chk("r_f_regw",   32'(reg_write), 0);
        step(1'b1, 1'b1, 1'b0, R_OP);
        chk("r_d_state",  32'(state), 1);
        chk("r_d_srca",   32'(alu_src_a), 2);
        chk("r_d_srcb",   32'(alu_src_b), 2);
        chk("r_d_req",    32'(mem_req), 0);
        step(1'b1, 1'b1, 1'b0, R_OP);
        chk("r_e_state",  32'(state), 2);
        chk("r_e_srca",   32'(alu_src_a), 1);
        chk("r_e_srcb",   32'(alu_src_b), 0);
        chk("r_e_op",     32'(alu_op), 2);
        chk("r_e_regw",   32'(reg_write), 0);
        step(1'b1, 1'b1, 1'b0, LD_OP);
        chk("r_w_state",  32'(state), 4);
        chk("r_w_regw",   32'(reg_write), 1);
        chk("r_w_wbsel",  32'(wb_sel), 0);

        // LOAD with two wait cycles in MEM
        step(1'b1, 1'b1, 1'b0, LD_OP);
        chk("ld_f_state", 32'(state), 0);
        chk("r_instret",  instret, 1);
        step(1'b1, 1'b1, 1'b0, LD_OP);
        chk("ld_d_state", 32'(state), 1);
        step(1'b1, 1'b1, 1'b0, LD_OP);
        chk("ld_e_state", 32'(state), 2);
        chk("ld_e_srcb",  32'(alu_src_b), 2);
        chk("ld_e_op",    32'(alu_op), 0);
        step(1'b1, 1'b0, 1'b0, LD_OP);
        chk("ld_m1_state", 32'(state), 3);
        chk("ld_m1_req",   32'(mem_req), 1);
        chk("ld_m1_we",    32'(mem_we), 0);
        step(1'b1, 1'b0, 1'b0, LD_OP);
        chk("ld_m2_state", 32'(state), 3);
        chk("ld_m2_req",   32'(mem_req), 1);
        step(1'b1, 1'b1, 1'b0, LD_OP);
        chk("ld_m3_state", 32'(state), 3);
        chk("ld_m3_req",   32'(mem_req), 1);
        step(1'b1, 1'b1, 1'b0, BR_OP);
        chk("ld_w_state", 32'(state), 4);
        chk("ld_w_wbsel", 32'(wb_sel), 1);
        chk("ld_w_regw",  32'(reg_write), 1);
        chk("ld_w_instret", instret, 1);

        // BRANCH taken, then not taken
        step(1'b1, 1'b1, 1'b0, BR_OP);
        chk("br1_f_state", 32'(state), 0);
        chk("ld_instret",  instret, 2);
        step(1'b1, 1'b1, 1'b0, BR_OP);
        step(1'b1, 1'b1, 1'b1, BR_OP);
        chk("br1_e_state",  32'(state), 2);
        chk("br1_e_branch", 32'(branch), 1);
        chk("br1_e_pcw",    32'(pc_write), 1);
        chk("br1_e_pcsrc",  32'(pc_src), 1);
        chk("br1_e_op",     32'(alu_op), 1);
        step(1'b1, 1'b1, 1'b0, BR_OP);
        chk("br2_f_state", 32'(state), 0);
        chk("br1_instret", instret, 3);
        step(1'b1, 1'b1, 1'b0, BR_OP);
        step(1'b1, 1'b1, 1'b0, ST_OP);
        chk("br2_e_state",  32'(state), 2);
        chk("br2_e_branch", 32'(branch), 1);
        chk("br2_e_pcw",    32'(pc_write), 0);
        chk("br2_e_pcsrc",  32'(pc_src), 1);

        // STORE with zero-wait memory
        step(1'b1, 1'b1, 1'b0, ST_OP);
        chk("st_f_state", 32'(state), 0);
        chk("br2_instret", instret, 4);
        step(1'b1, 1'b1, 1'b0, ST_OP);
        step(1'b1, 1'b1, 1'b0, ST_OP);
        chk("st_e_state", 32'(state), 2);
        step(1'b1, 1'b1, 1'b0, SYS_OP);
        chk("st_m_state", 32'(state), 3);
        chk("st_m_req",   32'(mem_req), 1);
        chk("st_m_we",    32'(mem_we), 1);

        // SYSTEM retires as a NOP when SYSTEM_HALT=0
        step(1'b1, 1'b1, 1'b0, SYS_OP);
        chk("sys_f_state", 32'(state), 0);
        chk("st_instret",  instret, 5);
        step(1'b1, 1'b1, 1'b0, SYS_OP);
        chk("sys_d_state", 32'(state), 1);
        step(1'b1, 1'b1, 1'b0, JAL_OP);
        chk("sys_ret_state", 32'(state), 0);
        chk("sys_instret",   instret, 6);
        chk("sys_halted",    32'(halted), 0);

        // JAL
        step(1'b1, 1'b1, 1'b0, JAL_OP);
        step(1'b1, 1'b1, 1'b0, JAL_OP);
        chk("jal_e_state", 32'(state), 2);
        chk("jal_e_pcw",   32'(pc_write), 1);
        chk("jal_e_pcsrc", 32'(pc_src), 1);
        chk("jal_e_regw",  32'(reg_write), 1);
        chk("jal_e_wbsel", 32'(wb_sel), 2);

        // Timeout: mem_ready held low in FETCH, limit 3
        step(1'b1, 1'b0, 1'b0, JAL_OP);
        chk("to_w0_state", 32'(state), 0);
        chk("jal_instret", instret, 7);
        step(1'b1, 1'b0, 1'b0, JAL_OP);
        chk("to_w1_state", 32'(state), 0);
        step(1'b1, 1'b0, 1'b0, JAL_OP);
        chk("to_w2_state", 32'(state), 0);
        step(1'b1, 1'b0, 1'b0, JAL_OP);
        chk("to_w3_state", 32'(state), 0);
        chk("to_w3_req",   32'(mem_req), 1);
        chk("to_w3_flag",  32'(timeout), 0);
        step(1'b1, 1'b0, 1'b0, JAL_OP);
        chk("to_h_state",   32'(state), 5);
        chk("to_h_timeout", 32'(timeout), 1);
        chk("to_h_halted",  32'(halted), 1);
        chk("to_h_req",     32'(mem_req), 0);
        chk("to_h_instret", instret, 7);
        step(1'b1, 1'b1, 1'b0, R_OP);
        chk("to_h2_state",  32'(state), 5);
        chk("to_h2_irw",    32'(ir_write), 0);

        // One-cycle reset recovers from HALT
        step(1'b0, 1'b1, 1'b0, BAD_OP);
        chk("to_rst_halted", 32'(halted), 0);
        step(1'b1, 1'b1, 1'b0, BAD_OP);
        chk("to_rec_state",   32'(state), 0);
        chk("to_rec_timeout", 32'(timeout), 0);
        chk("to_rec_halted",  32'(halted), 0);
        chk("to_rec_instret", instret, 0);

        // Illegal opcode
        step(1'b1, 1'b1, 1'b0, BAD_OP);
        chk("il_d_state", 32'(state), 1);
        step(1'b1, 1'b1, 1'b0, BAD_OP);
        chk("il_h_state",   32'(state), 5);
        chk("il_h_illegal", 32'(illegal), 1);
        chk("il_h_halted",  32'(halted), 1);
        chk("il_h_instret", instret, 0);
        step(1'b0, 1'b1, 1'b0, ST_OP);
        step(1'b1, 1'b1, 1'b0, ST_OP);
        chk("il_rec_state",   32'(state), 0);
        chk("il_rec_illegal", 32'(illegal), 0);

        // Reset during a STORE memory wait
        step(1'b1, 1'b1, 1'b0, ST_OP);
        step(1'b1, 1'b1, 1'b0, ST_OP);
        step(1'b1, 1'b0, 1'b0, ST_OP);
        chk("sr_m_state", 32'(state), 3);
        chk("sr_m_we",    32'(mem_we), 1);
        step(1'b0, 1'b0, 1'b0, ST_OP);
        chk("sr_rst_we",  32'(mem_we), 0);
        chk("sr_rst_req", 32'(mem_req), 0);
        step(1'b1, 1'b0, 1'b0, ST_OP);
        chk("sr_rec_state",   32'(state), 0);
        chk("sr_rec_we",      32'(mem_we), 0);
        chk("sr_rec_req",     32'(mem_req), 1);
        chk("sr_rec_instret", instret, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequential control unit for the multi-cycle RV32I datapath. It is the successor to the single-cycle opcode decoder: the same opcode classes now step through a FETCH/DECODE/EXEC/MEM/WB state machine. It adds a ready-based memory handshake with a wait timeout, illegal-opcode and SYSTEM handling, and a retired-instruction counter. It sits between the instruction register (opcode in), the shared instruction/data memory port, and the datapath mux/enable controls.

## Interface
- `MEM_TIMEOUT`, default 15: maximum wait cycles per memory access; 0 disables the timeout.
- `SYSTEM_HALT`, default 1: 1 = opcode 1110011 halts; 0 = it retires as a NOP.
- `CNT_W`, default 32: width of `instret`.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `opcode` in 7: instruction bits [6:0] from the instruction register; valid in DECODE.
- `mem_ready` in 1: the memory access completes this cycle. Ignored when `mem_req`=0.
- `branch_taken` in 1: ALU compare result, sampled in EXEC of a branch.
- `mem_req`, `mem_we` out 1 each: memory request and write enable.
- `ir_write`, `pc_write` out 1 each: instruction register and PC load enables.
- `pc_src` out 1: PC source. 0 = ALU result; 1 = target register (ALUOut latched in DECODE).
- `alu_src_a` out 2: 00 = PC, 01 = rs1, 10 = old PC.
- `alu_src_b` out 2: 00 = rs2, 01 = constant 4, 10 = immediate.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = funct-decoded, 11 = pass B.
- `reg_write` out 1: register file write enable.
- `wb_sel` out 2: 00 = ALUOut, 01 = memory data, 10 = PC (already +4), 11 = immediate.
- `branch` out 1: asserted in EXEC of a branch.
- `state` out 3: current state encoding.
- `illegal`, `timeout`, `halted` out 1 each: sticky status flags.
- `instret` out CNT_W: retired-instruction count.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Encodings 6 and 7 go to HALT and set `illegal`.
- Outputs are decoded combinationally from the state and the latched opcode register `opc_q`. Unlisted outputs are 0.
- **FETCH**
  - Outputs: `mem_req`=1, `alu_src_a`=00, `alu_src_b`=01, `alu_op`=00.
  - On `mem_ready`: `ir_write`=1, `pc_write`=1, `pc_src`=0, then go to DECODE.
- **DECODE**
  - Latch `opcode` into `opc_q`.
  - Compute the target: `alu_src_a`=10, `alu_src_b`=10, `alu_op`=00.
  - Next state: legal opcode → EXEC. SYSTEM → HALT if SYSTEM_HALT=1, otherwise retire and go to FETCH. Any other opcode → HALT and set `illegal`.
- **EXEC**, by opcode class:
  - R (0110011): a=01, b=00, op=10 → WB.
  - I-ALU (0010011): a=01, b=10, op=10 → WB.
  - LOAD (0000011) and STORE (0100011): a=01, b=10, op=00 → MEM.
  - BRANCH (1100011): a=01, b=00, op=01, `branch`=1, `pc_write`=`branch_taken`, `pc_src`=1 → FETCH.
  - JAL (1101111): `pc_write`=1, `pc_src`=1, `reg_write`=1, `wb_sel`=10 → FETCH.
  - JALR (1100111): a=01, b=10, op=00, `pc_write`=1, `pc_src`=0, `reg_write`=1, `wb_sel`=10 → FETCH.
  - LUI (0110111): `reg_write`=1, `wb_sel`=11, op=11 → FETCH.
  - AUIPC (0010111): a=10, b=10, op=00 → WB.
- **MEM**
  - Outputs: `mem_req`=1, `mem_we`=1 for STORE only.
  - On `mem_ready`: LOAD → WB; STORE → FETCH.
- **WB**: `reg_write`=1; `wb_sel`=01 for LOAD, otherwise 00 → FETCH.
- **HALT**: all controls 0; the block stays in HALT until reset.
- **Retirement**: `instret` increments by 1 on every transition into FETCH from a state other than FETCH. It wraps at 2^CNT_W.
- **Wait timer**
  - Counts cycles with `mem_req`=1 and `mem_ready`=0. Clears on handshake completion or state change.
  - When the count equals MEM_TIMEOUT while `mem_ready`=0: go to HALT and set `timeout`.
  - `mem_ready` in the limit cycle completes normally; the handshake wins.

## Timing
- Reset:
  - While `rst_n`=0, all outputs are forced to 0 combinationally.
  - At the reset edge: state=FETCH, `opc_q`=0, `instret`=0, timer=0, flags cleared.
  - Reset takes effect from any state, including during a pending memory wait. A request abandoned by reset is not retired.
- `halted` = (state==HALT). `illegal` and `timeout` are sticky until reset.
- Latency with zero-wait memory (`mem_ready` high in the first request cycle):
  - 3 cycles: branch, JAL, JALR, LUI.
  - 4 cycles: R, I-ALU, AUIPC, STORE.
  - 5 cycles: LOAD.
- Each wait cycle adds 1 to the latency.
- `mem_req` stays high and stable until `mem_ready` is sampled high. `mem_we` is constant for the whole request.

## Structure
- Package `ctrl_pkg` holds:
  - opcode constants;
  - the state enum;
  - `alu_src_a`, `alu_src_b`, `alu_op` and `wb_sel` encodings;
  - the retirement helper function.
- One sub-module, `mem_wait_timer`: counter width $clog2(MEM_TIMEOUT+1); inputs are the enable, done and clear signals; output is `expired`.

## Test plan
- Reset, then R-type with `mem_ready`=1 always → states 0,1,2,4,0; `reg_write` only in WB; `instret`=1 after 4 cycles.
- LOAD with 2 wait cycles in MEM → 7 cycles total; `mem_req` high for 3 MEM cycles; WB has `wb_sel`=01; `instret`=1.
- BRANCH with `branch_taken`=1, then again with 0 → `pc_write`=1 in EXEC only for the first; `pc_src`=1 in both.
- MEM_TIMEOUT=3 and `mem_ready` held low in FETCH → HALT after 3 wait cycles; `timeout`=1, `halted`=1, `instret` unchanged. Then `rst_n`=0 for 1 cycle → FETCH with flags cleared.
- Opcode 1111111 → HALT with `illegal`=1. Opcode 1110011 with SYSTEM_HALT=0 → back to FETCH, `instret` +1.
- Reset asserted during MEM of a STORE → next cycle FETCH, `mem_we`=0, `instret`=0.
